multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
//  Moore FSM sequencing the multicycle RV32I datapath. Drives ALU operand-select
//  muxes, result mux, PC/IR/regfile write enables and the memory request handshake.
//  One instruction passes through FETCH..writeback over 3-5+ cycles. Counts retired
//  instructions and traps on unsupported opcodes.
// PARAMETERS
//  CNT_W      32  width of retired-instruction counter
//  TRAP_EN    1   1: illegal opcode -> TRAP (halt); 0: treat as NOP (back to FETCH)
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   asynchronous, active-high reset
//  opcode       in   7   IR[6:0]
//  funct3       in   3   IR[14:12]; bit0 selects beq(0)/bne(1)
//  zero         in   1   ALU zero flag
//  mem_ready    in   1   memory completes current request this cycle
//  mem_req      out  1   memory access request
//  mem_write    out  1   request is a store
//  adr_src      out  1   0: address=PC, 1: address=ALUOut
//  ir_write     out  1   latch instruction and old PC
//  pc_write     out  1   PC <= result mux
//  reg_write    out  1   regfile write
//  alu_src_a    out  2   00 PC, 01 oldPC, 10 regA
//  alu_src_b    out  2   00 regB, 01 imm, 10 const 4
//  alu_op       out  2   00 add, 01 sub(compare), 10 decode funct
//  result_src   out  2   00 ALUOut, 01 mem data, 10 ALU result
//  illegal      out  1   high while in TRAP
//  retired      out  CNT_W  instructions completed since reset
// BEHAVIOUR
//  - All outputs decoded from state only (Moore), except pc_write in BRANCH and the
//    mem_ready-qualified strobes below. Unlisted outputs are 0 in each state.
//  - reset: state<=FETCH, retired<=0 immediately; while reset high all enables 0.
//    Reset during a memory wait abandons the access; no write enable asserts.
//  - FETCH: mem_req=1, adr_src=0, a=00, b=10, op=00, result_src=10. Hold while
//    !mem_ready. On mem_ready: ir_write=1, pc_write=1 same cycle -> DECODE.
//  - DECODE: a=01, b=01, op=00 (branch target into ALUOut). Next by opcode:
//    0000011/0100011 -> MEM_ADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I;
//    1101111 -> JAL; 1100011 -> BRANCH; other -> TRAP (TRAP_EN=1) or FETCH.
//  - MEM_ADR: a=10, b=01, op=00 -> MEM_RD (lw) / MEM_WR (sw).
//  - MEM_RD: mem_req=1, adr_src=1; wait mem_ready -> MEM_WB.
//  - MEM_WB: result_src=01, reg_write=1 -> FETCH.
//  - MEM_WR: mem_req=1, mem_write=1, adr_src=1; wait mem_ready -> FETCH.
//  - EXEC_R: a=10, b=00, op=10 -> ALU_WB.  EXEC_I: a=10, b=01, op=10 -> ALU_WB.
//  - ALU_WB: result_src=00, reg_write=1 -> FETCH.
//  - JAL: a=01, b=10, op=00, result_src=00, pc_write=1 (PC<=target) -> ALU_WB
//    (rd<=oldPC+4).
//  - BRANCH: a=10, b=00, op=01, result_src=00; pc_write=(zero^funct3[0]) -> FETCH.
//  - TRAP: illegal=1, all enables 0; exits only by reset.
//  - retired increments by 1 on each transition into FETCH from MEM_WB, MEM_WR,
//    ALU_WB, BRANCH (and illegal-as-NOP); wraps modulo 2^CNT_W.
//  - mem_req never drops mid-wait; mem_ready ignored in non-memory states.
//  - Downstream operand muxes are registered: selects must be valid the cycle
//    before the ALU consumes them; FSM holds selects stable for the full state.
// TESTING
//  1 reset high mid-FETCH wait -> state FETCH, retired=0, mem_req=1 after release.
//  2 add (0110011), mem_ready=1 -> FETCH,DECODE,EXEC_R,ALU_WB; reg_write 1 cycle;
//    retired 0->1.
//  3 lw, mem_ready delayed 3 cycles in MEM_RD -> mem_req/adr_src=1 held, then
//    MEM_WB with result_src=01, reg_write=1.
//  4 sw -> MEM_WR mem_write=1 until mem_ready; reg_write never asserted.
//  5 beq zero=1 -> pc_write=1 in BRANCH; bne(funct3=001) zero=1 -> pc_write=0.
//  6 opcode 7'h7F, TRAP_EN=1 -> TRAP, illegal=1, no enables for 20 cycles;
//    TRAP_EN=0 -> FETCH, retired+1.

Source files
------------

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle RV32I datapath.
// Ports: clk, reset (async, active-high); opcode, funct3, zero, mem_ready in;
//   mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//   alu_src_a, alu_src_b, alu_op, result_src, illegal, retired out.
module multicycle_control #(
  parameter int CNT_W   = 32,
  parameter bit TRAP_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD,
    S_MEM_WB, S_MEM_WR, S_EXEC_R, S_EXEC_I,
    S_ALU_WB, S_JAL, S_BRANCH, S_TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       adr_src;
    logic       reg_write;
    logic       pc_jal;
    logic       fetch;
    logic       branch;
    logic       illegal;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] op;
    logic [1:0] rs;
  } ctl_t;

  state_t           r_state;
  state_t           w_next;
  ctl_t             r_ctl;
  logic [CNT_W-1:0] r_retired;
  logic             w_fetch_done;
  logic             w_taken;
  logic             w_unused_f3;

  // Moore decode of a state; applied to the next state so the
  // control word is registered and valid for the whole state.
  function automatic ctl_t decode(state_t s);
    ctl_t c;
    c = '0;
    unique case (s)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.fetch   = 1'b1;
        c.b       = 2'b10;
        c.rs      = 2'b10;
      end
      S_DECODE: begin
        c.a = 2'b01;
        c.b = 2'b01;
      end
      S_MEM_ADR: begin
        c.a = 2'b10;
        c.b = 2'b01;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write = 1'b1;
        c.rs        = 2'b01;
      end
      S_MEM_WR: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        c.a  = 2'b10;
        c.op = 2'b10;
      end
      S_EXEC_I: begin
        c.a  = 2'b10;
        c.b  = 2'b01;
        c.op = 2'b10;
      end
      S_ALU_WB: c.reg_write = 1'b1;
      S_JAL: begin
        c.pc_jal = 1'b1;
        c.a      = 2'b01;
        c.b      = 2'b10;
      end
      S_BRANCH: begin
        c.branch = 1'b1;
        c.a      = 2'b10;
        c.op     = 2'b01;
      end
      S_TRAP: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          7'b0000011,
          7'b0100011: w_next = S_MEM_ADR;
          7'b0110011: w_next = S_EXEC_R;
          7'b0010011: w_next = S_EXEC_I;
          7'b1101111: w_next = S_JAL;
          7'b1100011: w_next = S_BRANCH;
          default:    w_next = TRAP_EN ? S_TRAP : S_FETCH;
        endcase
      end
      // IR is stable here: opcode[5] splits sw from lw
      S_MEM_ADR: w_next = opcode[5] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WB:  w_next = S_FETCH;
      S_MEM_WR:  if (mem_ready) w_next = S_FETCH;
      S_EXEC_R:  w_next = S_ALU_WB;
      S_EXEC_I:  w_next = S_ALU_WB;
      S_ALU_WB:  w_next = S_FETCH;
      S_JAL:     w_next = S_ALU_WB;
      S_BRANCH:  w_next = S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_ctl     <= decode(S_FETCH);
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctl   <= decode(w_next);
      // only a completed instruction re-enters FETCH
      if (r_state != S_FETCH && w_next == S_FETCH)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign w_fetch_done = r_ctl.fetch & mem_ready;
  assign w_taken      = r_ctl.branch & (zero ^ funct3[0]);
  assign w_unused_f3  = ^funct3[2:1];

  // strobes are forced low while reset is held
  assign mem_req    = r_ctl.mem_req & ~reset;
  assign mem_write  = r_ctl.mem_write & ~reset;
  assign ir_write   = w_fetch_done & ~reset;
  assign pc_write   = (w_fetch_done | r_ctl.pc_jal | w_taken) & ~reset;
  assign reg_write  = r_ctl.reg_write & ~reset;
  assign adr_src    = r_ctl.adr_src;
  assign alu_src_a  = r_ctl.a;
  assign alu_src_b  = r_ctl.b;
  assign alu_op     = r_ctl.op;
  assign result_src = r_ctl.rs;
  assign illegal    = r_ctl.illegal;
  assign retired    = r_retired;

endmodule
